meas_result_framer: RTL and testbench
=====================================

# meas_result_framer

Control and packing stage placed directly downstream of the digital signal measurement engine. On a single-cycle trigger it asserts `measure_start`, waits for `measure_done` or a timeout, and latches the four 16-bit results (high, low, period, duty). It then emits them as a checksummed byte frame on a valid/ready byte stream toward the host uplink.

## Interface
- `CMD_CODE`, 8'h0A: command byte placed in the frame.
- `TIMEOUT_CYCLES`, 32'd50_000_000: cycles in ARM before a timeout. 0 disables the timeout.
- `clk`  in  1  system clock; all logic on posedge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `trig`  in  1  one-cycle request to start a measurement.
- `measure_start`  out  1  held high to the measurement engine while armed.
- `measure_done`  in  1  level from the engine; results are valid while high.
- `high_time`, `low_time`, `period_time`, `duty_cycle`  in  16 each  engine results.
- `busy`  out  1  high in every state except IDLE.
- `tx_data`  out  8  frame byte.
- `tx_valid`  out  1  byte valid.
- `tx_ready`  in  1  sink accepts the byte.
- `tx_last`  out  1  high with the checksum byte.

## Operation
- Frame, 14 bytes, in order:
  - 0xAA, 0x55, `CMD_CODE`, LEN=0x09, STATUS
  - high_time, low_time, period_time, duty_cycle, each as MSB then LSB
  - CHK
- STATUS: bit0 = timeout; other bits 0.
- CHK = 8-bit modulo sum of CMD through the last data byte. The two header bytes are excluded.
- States:
  - **IDLE**: go to ARM when `trig`=1 and `measure_done`=0. Otherwise `trig` is ignored.
  - **ARM**: `measure_start`=1 and the timeout counter increments.
    - `measure_done`=1: latch all four inputs, STATUS=0x00, go to SEND.
    - Counter reaches `TIMEOUT_CYCLES`-1 (when enabled): data regs=0, STATUS=0x01, go to SEND.
    - If both happen in the same cycle, `measure_done` wins.
  - **SEND**: `measure_start`=0. A 4-bit byte index runs 0..13. The index advances on `tx_valid`&&`tx_ready`. Acceptance of index 13 returns to IDLE.
- Checksum: accumulated as bytes 2..12 are accepted, or computed combinationally from the latched regs. Either way, the byte presented at index 13 must equal the definition above.
- `trig` while `busy` is dropped, not queued.
- The framer never resets the engine. After a timeout the engine may still be waiting for an edge, and the next ARM re-asserts `measure_start` against it.
- Duty is forwarded unmodified; the framer performs no arithmetic on it.

## Timing
- Reset values: `measure_start`=0, `busy`=0, `tx_valid`=0, `tx_last`=0, `tx_data`=0x00. The byte index, timeout counter, data regs and STATUS are all cleared.
- Reset asserted mid-frame aborts the frame. All outputs are at reset values after the next edge, and no partial frame resumes.
- `trig` sampled at edge N: `busy`=1 and `measure_start`=1 from N+1.
- `measure_done` sampled high at edge M:
  - inputs are latched at M;
  - from M+1, `measure_start`=0, `tx_valid`=1, `tx_data`=0xAA.
- Stream rules:
  - `tx_data` and `tx_last` stay stable while `tx_valid`&&!`tx_ready`.
  - `tx_valid` does not drop mid-frame.
  - With `tx_ready` tied high, the frame takes exactly 14 cycles.
- Last byte accepted at edge K: `tx_valid`=0 and `busy`=0 from K+1. A new `trig` is accepted at K+1 only if `measure_done` has already cleared.
- Timeout counter clears on entry to ARM. A timeout fires on the `TIMEOUT_CYCLES`-th ARM cycle.

## Structure
- Package `meas_frame_pkg` holds:
  - header constants 0xAA and 0x55;
  - LEN=9 and frame size 14;
  - STATUS bit positions;
  - the state enum {IDLE, ARM, SEND}.
- Single module; no sub-module is required. Byte selection is a case on the byte index.

## Test plan
- Normal frame: high=300, low=700, period=1000, duty=30, `tx_ready`=1, done pulse after 20 cycles -> bytes AA 55 0A 09 00 01 2C 02 BC 03 E8 00 1E 07, `tx_last` on 07, `measure_start` low from the first byte.
- Backpressure: same data, `tx_ready` toggled 1-0-0-1 pseudo-randomly -> identical byte sequence, no byte repeated or skipped, data stable while stalled.
- Timeout: `TIMEOUT_CYCLES`=100, `measure_done` never asserted -> SEND entered after 100 ARM cycles, frame AA 55 0A 09 01 00×8 14.
- Trigger filtering: `trig` pulses during ARM and SEND, and `trig` while `measure_done`=1 -> all ignored, exactly one frame per accepted trigger.
- Done/timeout collision: `measure_done` rises on the same cycle the timeout fires -> STATUS=0x00 and real data sent.
- Reset mid-frame: `rst_n` low for one cycle at byte index 6 -> all outputs zero the next cycle; a following `trig` yields a complete fresh frame starting with 0xAA.

Source files
------------

// File: rtl/meas_result_framer_pkg.sv
// Shared constants and state type for the measurement result framer.
// Frame layout: AA 55 CMD LEN STATUS, four 16-bit results MSB first, then CHK.
package meas_frame_pkg;

    localparam logic [7:0] HDR0       = 8'hAA;
    localparam logic [7:0] HDR1       = 8'h55;
    localparam logic [7:0] FRAME_LEN  = 8'h09;
    localparam int         FRAME_BYTES = 14;
    localparam logic [3:0] LAST_IDX   = 4'(FRAME_BYTES - 1);

    localparam int STATUS_TIMEOUT_BIT = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        SEND = 2'd2
    } state_e;

endpackage

// File: rtl/meas_result_framer_if.sv
// Bundles the engine control/result signals and the outbound byte stream.
// Byte stream: a byte transfers on a rising edge where tx_valid && tx_ready; once tx_valid
// is high, tx_data/tx_last hold until that transfer and tx_valid stays high for the frame.
interface meas_result_framer_if;

    logic        trig;
    logic        busy;
    logic        measure_start;
    logic        measure_done;
    logic [15:0] high_time;
    logic [15:0] low_time;
    logic [15:0] period_time;
    logic [15:0] duty_cycle;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_last;

    modport master (
        input  trig, measure_done, high_time, low_time, period_time, duty_cycle, tx_ready,
        output busy, measure_start, tx_data, tx_valid, tx_last
    );

    modport slave (
        output trig, measure_done, high_time, low_time, period_time, duty_cycle, tx_ready,
        input  busy, measure_start, tx_data, tx_valid, tx_last
    );

endinterface

// File: rtl/meas_result_framer.sv
// Arms the measurement engine on trig, captures its results (or a timeout),
// and streams them out as a 14-byte checksummed frame.
module meas_result_framer
    import meas_frame_pkg::*;
#(
    parameter logic [7:0]  CMD_CODE       = 8'h0A,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    meas_result_framer_if.master bus,
    output state_e               dbg_state_o
);

    state_e      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [31:0] tmo_q, tmo_d;
    logic [15:0] high_q, high_d;
    logic [15:0] low_q, low_d;
    logic [15:0] per_q, per_d;
    logic [15:0] duty_q, duty_d;
    logic [7:0]  status_q, status_d;
    logic [7:0]  chk;
    logic        tmo_hit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            tmo_q    <= '0;
            high_q   <= '0;
            low_q    <= '0;
            per_q    <= '0;
            duty_q   <= '0;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            tmo_q    <= tmo_d;
            high_q   <= high_d;
            low_q    <= low_d;
            per_q    <= per_d;
            duty_q   <= duty_d;
            status_q <= status_d;
        end
    end

    // Timeout fires on the TIMEOUT_CYCLES-th ARM cycle (counter starts at 0).
    assign tmo_hit = (TIMEOUT_CYCLES != 32'd0) && (tmo_q == TIMEOUT_CYCLES - 32'd1);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        tmo_d    = tmo_q;
        high_d   = high_q;
        low_d    = low_q;
        per_d    = per_q;
        duty_d   = duty_q;
        status_d = status_q;
        unique case (state_q)
            IDLE: begin
                tmo_d = '0;
                idx_d = '0;
                if (bus.trig && !bus.measure_done) begin
                    state_d = ARM;
                end
            end
            ARM: begin
                tmo_d = tmo_q + 32'd1;
                if (bus.measure_done) begin
                    high_d   = bus.high_time;
                    low_d    = bus.low_time;
                    per_d    = bus.period_time;
                    duty_d   = bus.duty_cycle;
                    status_d = '0;
                    idx_d    = '0;
                    state_d  = SEND;
                end else if (tmo_hit) begin
                    high_d   = '0;
                    low_d    = '0;
                    per_d    = '0;
                    duty_d   = '0;
                    status_d = '0;
                    status_d[STATUS_TIMEOUT_BIT] = 1'b1;
                    idx_d    = '0;
                    state_d  = SEND;
                end
            end
            SEND: begin
                if (bus.tx_ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Checksum covers CMD through the last data byte; header bytes excluded.
    assign chk = CMD_CODE + FRAME_LEN + status_q
               + high_q[15:8] + high_q[7:0] + low_q[15:8] + low_q[7:0]
               + per_q[15:8]  + per_q[7:0]  + duty_q[15:8] + duty_q[7:0];

    always_comb begin
        bus.tx_data = 8'h00;
        if (state_q == SEND) begin
            case (idx_q)
                4'd0:    bus.tx_data = HDR0;
                4'd1:    bus.tx_data = HDR1;
                4'd2:    bus.tx_data = CMD_CODE;
                4'd3:    bus.tx_data = FRAME_LEN;
                4'd4:    bus.tx_data = status_q;
                4'd5:    bus.tx_data = high_q[15:8];
                4'd6:    bus.tx_data = high_q[7:0];
                4'd7:    bus.tx_data = low_q[15:8];
                4'd8:    bus.tx_data = low_q[7:0];
                4'd9:    bus.tx_data = per_q[15:8];
                4'd10:   bus.tx_data = per_q[7:0];
                4'd11:   bus.tx_data = duty_q[15:8];
                4'd12:   bus.tx_data = duty_q[7:0];
                default: bus.tx_data = chk;
            endcase
        end
    end

    assign bus.tx_valid      = (state_q == SEND);
    assign bus.tx_last       = (state_q == SEND) && (idx_q == LAST_IDX);
    assign bus.measure_start = (state_q == ARM);
    assign bus.busy          = (state_q != IDLE);
    assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_meas_result_framer.sv
// Randomized bench for meas_result_framer: a frame model feeds an expected-byte
// queue, and an independent monitor pops and compares every accepted byte.
module tb_meas_result_framer;
    import meas_frame_pkg::*;

    localparam int T = 100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    meas_result_framer_if bus();
    state_e dbg_state;

    meas_result_framer #(
        .CMD_CODE       (8'h0A),
        .TIMEOUT_CYCLES (32'd100)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    logic [8:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    bit bp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Frame model: header, cmd, len, status, results MSB-first, 8-bit sum of bytes 2..12.
    task automatic push_frame(input logic [15:0] h, input logic [15:0] l,
                              input logic [15:0] p, input logic [15:0] d,
                              input logic [7:0] status);
        int b[14];
        int sum;
        b[0] = 8'hAA; b[1] = 8'h55; b[2] = 8'h0A; b[3] = 9; b[4] = status;
        b[5] = h / 256; b[6] = h % 256; b[7] = l / 256; b[8] = l % 256;
        b[9] = p / 256; b[10] = p % 256; b[11] = d / 256; b[12] = d % 256;
        sum = 0;
        for (int i = 2; i <= 12; i++) sum += b[i];
        b[13] = sum % 256;
        for (int i = 0; i < 14; i++) exp_q.push_back({(i == 13), 8'(b[i])});
    endtask

    task automatic garble();
        bus.high_time   = 16'($urandom);
        bus.low_time    = 16'($urandom);
        bus.period_time = 16'($urandom);
        bus.duty_cycle  = 16'($urandom);
    endtask

    // done_after: ARM cycle (1..T) on whose closing edge done is sampled; 0 = never.
    task automatic run_frame(input logic [15:0] h, input logic [15:0] l,
                             input logic [15:0] p, input logic [15:0] d,
                             input int done_after, input bit bp, input bit filt);
        int n;
        bp_en = bp;
        tick();
        if (done_after >= 1) push_frame(h, l, p, d, 8'h00);
        else push_frame(16'd0, 16'd0, 16'd0, 16'd0, 8'h01);
        bus.trig = 1'b1;
        tick();
        bus.trig = 1'b0;
        check("arm_busy", 32'(bus.busy), 32'd1);
        check("arm_start", 32'(bus.measure_start), 32'd1);
        if (done_after >= 1) begin
            repeat (done_after - 1) begin
                bus.trig = filt ? 1'($urandom_range(0, 1)) : 1'b0;
                garble();
                tick();
            end
            bus.trig = 1'b0;
            bus.measure_done = 1'b1;
            bus.high_time = h; bus.low_time = l; bus.period_time = p; bus.duty_cycle = d;
            tick();
            bus.measure_done = 1'b0;
            garble();
            check("done_valid", 32'(bus.tx_valid), 32'd1);
            check("done_start_low", 32'(bus.measure_start), 32'd0);
            check("done_first_byte", 32'(bus.tx_data), 32'hAA);
        end else begin
            repeat (T - 1) begin
                bus.trig = filt ? 1'($urandom_range(0, 1)) : 1'b0;
                garble();
                tick();
            end
            bus.trig = 1'b0;
            check("tmo_not_early", 32'(bus.tx_valid), 32'd0);
            tick();
            check("tmo_entry", 32'(bus.tx_valid), 32'd1);
            check("tmo_start_low", 32'(bus.measure_start), 32'd0);
        end
        n = 0;
        while (bus.busy && n < 400) begin
            bus.trig = filt ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
            n++;
        end
        bus.trig = 1'b0;
        check("frame_end_busy", 32'(bus.busy), 32'd0);
        check("frame_end_valid", 32'(bus.tx_valid), 32'd0);
        if (!bp) check("frame_cycles", 32'(n), 32'd14);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            bus.tx_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: compares accepted bytes and checks the stream rules.
    initial begin
        int seen;
        bit prev_stall;
        logic [8:0] prev;
        logic [8:0] e;
        seen = 0;
        prev_stall = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen = 0;
                prev_stall = 1'b0;
            end else begin
                if (prev_stall)
                    check("stall_hold", 32'({bus.tx_valid, bus.tx_last, bus.tx_data}), 32'({1'b1, prev}));
                if (seen > 0) check("valid_hold", 32'(bus.tx_valid), 32'd1);
                if (bus.tx_valid && bus.tx_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_byte: got %h want none at %0t", bus.tx_data, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("byte", 32'({bus.tx_last, bus.tx_data}), 32'(e));
                        check("start_low_in_send", 32'(bus.measure_start), 32'd0);
                    end
                    seen = (seen == 13) ? 0 : seen + 1;
                end
                prev_stall = bus.tx_valid && !bus.tx_ready;
                prev = {bus.tx_last, bus.tx_data};
            end
        end
    end

    initial begin
        bus.trig = 1'b0;
        bus.measure_done = 1'b0;
        bus.tx_ready = 1'b1;
        garble();
        rst_n = 1'b0;
        repeat (3) tick();
        check("rst_start", 32'(bus.measure_start), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_valid", 32'(bus.tx_valid), 32'd0);
        check("rst_last", 32'(bus.tx_last), 32'd0);
        check("rst_data", 32'(bus.tx_data), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        rst_n = 1'b1;
        tick();

        run_frame(16'd300, 16'd700, 16'd1000, 16'd30, 20, 1'b0, 1'b0);
        run_frame(16'd300, 16'd700, 16'd1000, 16'd30, 20, 1'b1, 1'b0);
        run_frame(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 0, 1'b0, 1'b0);
        run_frame(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), T, 1'b0, 1'b0);
        run_frame(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 0, 1'b1, 1'b1);

        // trig while done is still high must be ignored
        bus.measure_done = 1'b1;
        bus.trig = 1'b1;
        tick();
        bus.trig = 1'b0;
        check("trig_done_high", 32'(bus.busy), 32'd0);
        tick();
        bus.measure_done = 1'b0;
        check("trig_done_high2", 32'(bus.busy), 32'd0);

        for (int k = 0; k < 8; k++) begin
            run_frame(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                      $urandom_range(1, 30), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // reset at byte index 6
        bp_en = 1'b0;
        tick();
        push_frame(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 8'h00);
        bus.trig = 1'b1;
        tick();
        bus.trig = 1'b0;
        tick();
        bus.measure_done = 1'b1;
        bus.high_time = 16'h1234; bus.low_time = 16'h5678;
        bus.period_time = 16'h9ABC; bus.duty_cycle = 16'hDEF0;
        tick();
        bus.measure_done = 1'b0;
        repeat (6) tick();
        check("mid_idx6_byte", 32'(bus.tx_data), 32'h34);
        rst_n = 1'b0;
        tick();
        check("midrst_start", 32'(bus.measure_start), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_valid", 32'(bus.tx_valid), 32'd0);
        check("midrst_last", 32'(bus.tx_last), 32'd0);
        check("midrst_data", 32'(bus.tx_data), 32'd0);
        exp_q.delete();
        rst_n = 1'b1;
        tick();
        run_frame(16'd300, 16'd700, 16'd1000, 16'd30, 5, 1'b0, 1'b0);

        repeat (5) tick();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
